counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl.sv | 175 +++++++++++++++++
 tb/tb_counter_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : counter_ctrl
// Wishbone-programmed sequencer for an external up-counter: load, run to a
// limit, then hold (one-shot) or reload (periodic), with a sticky match irq.
// Rev    : 1.0
// ============================================================================
module counter_ctrl #(
  parameter int BITS = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rstn_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [BITS-1:0] cnt_value,
  output logic            cnt_en,
  output logic            cnt_load,
  output logic [BITS-1:0] cnt_load_val,
  output logic            irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_LOAD   = 2'd1;
  localparam logic [1:0] ADR_LIMIT  = 2'd2;
  localparam logic [1:0] ADR_STATUS = 2'd3;

  localparam int WB_BITS = (BITS < 32) ? BITS : 32;

  logic [1:0]      state_q, state_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic            oneshot_q, oneshot_d;
  logic            irq_en_q, irq_en_d;
  logic [BITS-1:0] load_q, load_d;
  logic [BITS-1:0] limit_q, limit_d;
  logic            match_q, match_d;

  logic            valid;
  logic            accept;
  logic [1:0]      reg_sel;
  logic            wr_ctrl, wr_load, wr_limit, wr_status;
  logic            start, stop, hit;
  logic [31:0]     load_rd, limit_rd;
  logic [31:0]     rdata;
  logic            unused_bits;

  assign valid   = wbs_cyc_i & wbs_stb_i;
  // A transfer is taken only when no ack is pending, giving the one-idle-cycle spacing.
  assign accept  = valid & ~ack_q;
  assign reg_sel = wbs_adr_i[3:2];

  assign wr_ctrl   = accept & wbs_we_i & (reg_sel == ADR_CTRL) & wbs_sel_i[0];
  assign wr_load   = accept & wbs_we_i & (reg_sel == ADR_LOAD);
  assign wr_limit  = accept & wbs_we_i & (reg_sel == ADR_LIMIT);
  assign wr_status = accept & wbs_we_i & (reg_sel == ADR_STATUS) & wbs_sel_i[0];

  assign start = wr_ctrl & wbs_dat_i[0];
  assign stop  = wr_ctrl & wbs_dat_i[1];
  assign hit   = (state_q == ST_RUN) && (cnt_value == limit_q);

  assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

  generate
    if (BITS >= 32) begin : g_rd_wide
      assign load_rd  = load_q[31:0];
      assign limit_rd = limit_q[31:0];
    end else begin : g_rd_narrow
      assign load_rd  = {{(32-BITS){1'b0}}, load_q};
      assign limit_rd = {{(32-BITS){1'b0}}, limit_q};
    end
  endgenerate

  always_comb begin : read_mux
    rdata = '0;
    case (reg_sel)
      ADR_CTRL:   rdata = {28'd0, irq_en_q, oneshot_q, 2'b00};
      ADR_LOAD:   rdata = load_rd;
      ADR_LIMIT:  rdata = limit_rd;
      ADR_STATUS: rdata = {29'd0, match_q, state_q};
      default:    rdata = '0;
    endcase
  end

  always_comb begin : regs_next
    ack_d     = accept;
    dat_d     = accept ? rdata : dat_q;
    oneshot_d = oneshot_q;
    irq_en_d  = irq_en_q;
    load_d    = load_q;
    limit_d   = limit_q;
    match_d   = match_q;
    if (wr_ctrl) begin
      oneshot_d = wbs_dat_i[2];
      irq_en_d  = wbs_dat_i[3];
    end
    for (int i = 0; i < WB_BITS; i++) begin
      if (wr_load && wbs_sel_i[i/8]) load_d[i] = wbs_dat_i[i];
      if (wr_limit && wbs_sel_i[i/8]) limit_d[i] = wbs_dat_i[i];
    end
    // Setting wins over a same-cycle write-1-to-clear.
    if (wr_status && wbs_dat_i[2]) match_d = 1'b0;
    if (hit) match_d = 1'b1;
  end

  always_comb begin : fsm_next
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: state_d = ST_RUN;
        ST_RUN:  if (hit) state_d = oneshot_q ? ST_HOLD : ST_LOAD;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin : fsm_reg
    if (!wb_rstn_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge wb_clk_i) begin : regs
    if (!wb_rstn_i) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      oneshot_q <= 1'b0;
      irq_en_q  <= 1'b0;
      load_q    <= '0;
      limit_q   <= '0;
      match_q   <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      oneshot_q <= oneshot_d;
      irq_en_q  <= irq_en_d;
      load_q    <= load_d;
      limit_q   <= limit_d;
      match_q   <= match_d;
    end
  end

  always_comb begin : fsm_out
    cnt_en       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    case (state_q)
      ST_LOAD: begin
        cnt_load     = 1'b1;
        cnt_load_val = load_q;
      end
      ST_RUN:  cnt_en = 1'b1;
      default: cnt_en = 1'b0;
    endcase
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = match_q & irq_en_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_counter_ctrl
// Directed self-checking bench for counter_ctrl with a behavioural up-counter.
// Rev    : 1.0
// ============================================================================
module tb_counter_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [31:0] cnt;
  logic        cnt_en, cnt_load, irq;
  logic [31:0] cnt_load_val;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_ctrl #(.BITS(32)) dut (
    .wb_clk_i     (clk),
    .wb_rstn_i    (rstn),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (wdat),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (rdat),
    .cnt_value    (cnt),
    .cnt_en       (cnt_en),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .irq          (irq)
  );

  // Controlled counter model
  always @(posedge clk) begin
    if (!rstn)         cnt <= '0;
    else if (cnt_load) cnt <= cnt_load_val;
    else if (cnt_en)   cnt <= cnt + 32'd1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns 1ns after the ack edge; lat counts edges from request to ack.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int lat);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    lat = 0;
    while (lat < 8) begin
      @(posedge clk);
      #1;
      lat++;
      if (ack) break;
    end
    check("ack", {63'd0, ack}, 64'd1);
    rd  = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    int          lat;
    xfer(1'b1, a, d, s, rd, lat);
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
    int lat;
    xfer(1'b0, a, 32'd0, 4'hF, d, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          lat;

    rstn = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; adr = '0; wdat = '0;
    tick(3);
    check("reset_outputs", {ack, rdat, cnt_en, cnt_load, cnt_load_val, irq}, 64'd0);
    rstn = 1'b1;
    rd_reg(32'hC, d);
    check("reset_status", d, 32'd0);

    // Single write / byte-lane readback
    tick(1);
    xfer(1'b1, 32'h8, 32'h0000_00FF, 4'b0001, d, lat);
    check("ack_latency", lat, 1);
    rd_reg(32'h8, d);
    check("limit_rd_ff", d, 32'h0000_00FF);
    wr(32'h8, 32'hAAAA_AAAA, 4'b0010);
    rd_reg(32'h8, d);
    check("limit_rd_byte1", d, 32'h0000_AAFF);

    // One-shot: LOAD=5, LIMIT=8, START|ONESHOT|IRQ_EN
    wr(32'h4, 32'd5, 4'hF);
    wr(32'h8, 32'd8, 4'hF);
    wr(32'h0, 32'hD, 4'h1);
    check("oneshot_load", {cnt_load, cnt_en, cnt_load_val}, {1'b1, 1'b0, 32'd5});
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("oneshot_run", {cnt_en, cnt_load, cnt}, {1'b1, 1'b0, 32'(5 + i)});
    end
    tick(1);
    check("oneshot_hold", {cnt_en, cnt_load, irq}, 3'b001);
    rd_reg(32'hC, d);
    check("oneshot_status", d, 32'h7);
    rd_reg(32'h0, d);
    check("ctrl_readback", d, 32'hC);

    // Auto-reload: LOAD=0, LIMIT=3, periodic
    wr(32'h4, 32'd0, 4'hF);
    wr(32'h8, 32'd3, 4'hF);
    wr(32'h0, 32'h1, 4'h1);
    check("reload_first", {63'd0, cnt_load}, 64'd1);
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      check("reload_period", {63'd0, cnt_load}, {63'd0, (k % 5) == 0});
    end
    for (int r = 0; r < 3; r++) begin
      rd_reg(32'hC, d);
      check("reload_state", {63'd0, (d[1:0] == 2'd1) || (d[1:0] == 2'd2)}, 64'd1);
    end

    // W1C race against a compare hit
    wr(32'h0, 32'h2, 4'h1);
    wr(32'hC, 32'h4, 4'h1);
    rd_reg(32'hC, d);
    check("cleared_status", d, 32'h0);
    wr(32'h0, 32'hD, 4'h1);
    tick(4);
    check("pre_hit", {cnt_en, cnt}, {1'b1, 32'd3});
    wr(32'hC, 32'h4, 4'h1);
    check("race_irq", {63'd0, irq}, 64'd1);
    rd_reg(32'hC, d);
    check("race_status", d, 32'h7);
    wr(32'hC, 32'h4, 4'h1);
    check("irq_fall", {63'd0, irq}, 64'd0);
    rd_reg(32'hC, d);
    check("hold_status", d, 32'h3);

    // STOP beats START
    wr(32'h8, 32'd100, 4'hF);
    wr(32'h0, 32'h1, 4'h1);
    tick(2);
    check("run_before_stop", {63'd0, cnt_en}, 64'd1);
    wr(32'h0, 32'h3, 4'h1);
    check("stop_priority", {cnt_en, cnt_load}, 2'b00);
    rd_reg(32'hC, d);
    check("stop_status", d, 32'h0);

    // Reset in RUN with a request in flight
    wr(32'h0, 32'h1, 4'h1);
    tick(1);
    rd_reg(32'h8, d);
    check("limit_before_reset", d, 32'd100);
    check("run_before_reset", {63'd0, cnt_en}, 64'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8; sel = 4'hF;
    rstn = 1'b0;
    tick(1);
    check("midrun_reset", {ack, rdat, cnt_en, cnt_load, cnt_load_val, irq}, 64'd0);
    rstn = 1'b1;
    tick(1);
    check("post_reset_ack", {ack, rdat}, {1'b1, 32'd0});
    cyc = 1'b0; stb = 1'b0;
    tick(1);
    rd_reg(32'hC, d);
    check("post_reset_status", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
